// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed 32-bit data RAM behind a valid/ready request handshake with programmable wait states.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned or out-of-range addresses as error accesses.
`default_nettype none

module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [2**ADDR_W];

  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_err;
  logic              enter_resp;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt == 4'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accepting edge, so the
  // access uses the live request fields instead of the not-yet-latched copy.
  assign acc_we     = (state == IDLE) ? req_we    : we_q;
  assign acc_addr   = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata  = (state == IDLE) ? req_wdata : wdata_q;
  assign acc_idx    = acc_addr[ADDR_W+1:2];
  assign enter_resp = rst && (state != RESP) && (state_nxt == RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  assign acc_err  = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W+2] != '0);
  assign resp_err = (state == RESP) && err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            err_q <= 1'b0;
    else if (enter_resp) err_q <= acc_err;
  end
`else
  logic unused_addr_bits;

  assign acc_err          = 1'b0;
  assign resp_err         = 1'b0;
  assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[31:ADDR_W+2]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        wait_cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        if (acc_err) begin
          resp_rdata <= '0;
        end else if (acc_we) begin
          resp_rdata <= acc_wdata;
          wr_cnt     <= wr_cnt + 16'd1;
        end else begin
          resp_rdata <= mem[acc_idx];
          rd_cnt     <= rd_cnt + 16'd1;
        end
      end
    end
  end

  // RAM contents survive reset; enter_resp is already gated by rst.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance).
`default_nettype none

module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic [15:0] rd_cnt, wr_cnt;

  logic        v0, ready0, we0, rv0, err0, busy0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [15:0] rc0, wc0;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_ready(ready0), .req_we(we0),
    .req_addr(addr0), .req_wdata(wdata0),
    .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0),
    .busy(busy0), .rd_cnt(rc0), .wr_cnt(wc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on the main instance; expects response 3 cycles after acceptance.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag, output logic [31:0] rdata, output logic err);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_0BAD;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
      check({tag, "_wait_busy"}, {30'd0, busy, req_ready}, 32'd2);
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_resp_busy"}, 32'(busy), 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    check({tag, "_after"}, {30'd0, resp_valid, busy}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] b2b_data [3];
  int          resp_cyc [3];
  int          n, not_ready;

  initial begin
    b2b_data[0] = 32'hA0A0_0000;
    b2b_data[1] = 32'hA1A1_1111;
    b2b_data[2] = 32'hA2A2_2222;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    v0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_flags", {29'd0, resp_valid, resp_err, busy}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_cnts", {rd_cnt, wr_cnt}, 32'd0);
    rst = 1'b1;

    access(1'b1, 32'h10, 32'hDEAD_BEEF, "st10", rd, er);
    check("st10_rdata", rd, 32'hDEAD_BEEF);
    check("st10_wr_cnt", 32'(wr_cnt), 32'd1);
    access(1'b0, 32'h10, 32'h0, "ld10", rd, er);
    check("ld10_rdata", rd, 32'hDEAD_BEEF);
    check("ld10_err", 32'(er), 32'd0);
    check("ld10_rd_cnt", 32'(rd_cnt), 32'd1);
    access(1'b1, 32'h14, 32'h1, "st14", rd, er);
    access(1'b0, 32'h14, 32'h0, "ld14", rd, er);
    check("ld14_rdata", rd, 32'h0000_0001);
    check("cnts_a", {rd_cnt, wr_cnt}, {16'd2, 16'd2});

    // Back-to-back stores with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = b2b_data[0];
    n = 0; not_ready = 0;
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      @(negedge clk);
      if (!req_ready) not_ready++;
      if (resp_valid) begin
        resp_cyc[n] = cyc;
        n++;
        if (n < 3) begin
          req_addr = 32'(n * 4); req_wdata = b2b_data[n];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(n), 32'd3);
    check("b2b_resp0", 32'(resp_cyc[0]), 32'd2);
    check("b2b_resp1", 32'(resp_cyc[1]), 32'd6);
    check("b2b_resp2", 32'(resp_cyc[2]), 32'd10);
    check("b2b_not_ready", 32'(not_ready), 32'd9);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 32'(i * 4), 32'h0, "b2b_ld", rd, er);
      check("b2b_rdata", rd, b2b_data[i]);
    end
    check("cnts_b", {rd_cnt, wr_cnt}, {16'd5, 16'd5});

    // Reset during WAIT discards the pending store.
    access(1'b1, 32'h20, 32'h0, "pre20", rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rw_busy", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rw_flags", {28'd0, req_ready, resp_valid, resp_err, busy}, 32'd8);
    check("rw_rdata", resp_rdata, 32'd0);
    check("rw_cnts", {rd_cnt, wr_cnt}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // Reset during RESP: resp_valid drops at once, committed store survives.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_valid_hi", 32'(resp_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rr_valid_lo", {30'd0, resp_valid, busy}, 32'd0);
    @(negedge clk) rst = 1'b1;
    access(1'b0, 32'h30, 32'h0, "ld30", rd, er);
    check("ld30_rdata", rd, 32'h0000_0055);
    access(1'b0, 32'h20, 32'h0, "ld20", rd, er);
    check("ld20_rdata", rd, 32'h0);
    check("cnts_c", {rd_cnt, wr_cnt}, {16'd2, 16'd0});

    access(1'b1, 32'h22, 32'h1234_5678, "st22", rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    check("st22_err", 32'(er), 32'd1);
    check("st22_rdata", rd, 32'h0);
    check("st22_wr_cnt", 32'(wr_cnt), 32'd0);
    access(1'b0, 32'h20, 32'h0, "ld20b", rd, er);
    check("ld20b_rdata", rd, 32'h0);
    access(1'b0, 32'h1000, 32'h0, "ld1000", rd, er);
    check("ld1000_err", 32'(er), 32'd1);
    check("ld1000_rdata", rd, 32'h0);
    check("ld1000_rd_cnt", 32'(rd_cnt), 32'd3);
`else
    check("st22_err", 32'(er), 32'd0);
    check("st22_rdata", rd, 32'h1234_5678);
    check("st22_wr_cnt", 32'(wr_cnt), 32'd1);
    access(1'b0, 32'h20, 32'h0, "ld20b", rd, er);
    check("ld20b_rdata", rd, 32'h1234_5678);
    access(1'b0, 32'h1000, 32'h0, "ld1000", rd, er);
    check("ld1000_err", 32'(er), 32'd0);
    check("ld1000_rdata", rd, 32'hA0A0_0000);
    check("ld1000_rd_cnt", 32'(rd_cnt), 32'd4);
`endif

    // Zero-wait-state instance.
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h0000_0077;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    check("w0_st_valid", {30'd0, rv0, busy0}, 32'd3);
    check("w0_st_rdata", rdata0, 32'h0000_0077);
    @(negedge clk);
    check("w0_idle", {30'd0, rv0, ready0}, 32'd1);
    v0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    @(posedge clk); #1;
    v0 = 1'b0; addr0 = 32'h44;
    @(negedge clk);
    check("w0_ld_valid", 32'(rv0), 32'd1);
    check("w0_ld_rdata", rdata0, 32'h0000_0077);
    check("w0_cnts", {rc0, wc0}, {16'd1, 16'd1});
    @(negedge clk);
    check("w0_ld_after", 32'(rv0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
